bcd_stopwatch_ctrl: RTL

//  Upstream control stage for the two-digit 7-segment display driver: debounces the four raw

---
 rtl/bcd_stopwatch_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// Button debounce plus two-digit BCD up/down stopwatch counter feeding the 7-segment driver.
// Optional build macro HOLD_AT_LIMIT_EN: saturate at 99/00 and stop instead of wrapping.
module bcd_stopwatch_ctrl #(
  parameter int unsigned TICK_DIV        = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clck,
  input  logic       rst,
  input  logic [3:0] button,
  output logic [3:0] digit_0,
  output logic [3:0] digit_1,
  output logic       running,
  output logic       count_dir,
  output logic       tick,
  output logic [3:0] btn_pulse
);

  localparam int unsigned PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  logic [3:0]      sync1, sync2, db_lvl, db_q;
  logic [DB_W-1:0] db_cnt [4];
  state_t          state, state_nxt;
  logic [PS_W-1:0] presc, presc_nxt;
  logic [3:0]      ones_nxt, tens_nxt;
  logic            tick_nxt, dir_nxt, step_evt, step;
  logic            at_limit, lands_limit;

  // Synchronize, debounce and edge-detect each button independently
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      db_lvl    <= '0;
      db_q      <= '0;
      btn_pulse <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1     <= button;
      sync2     <= sync1;
      db_q      <= db_lvl;
      btn_pulse <= db_lvl & ~db_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      digit_0   <= '0;
      digit_1   <= '0;
      tick      <= 1'b0;
      count_dir <= 1'b1;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      digit_0   <= ones_nxt;
      digit_1   <= tens_nxt;
      tick      <= tick_nxt;
      count_dir <= dir_nxt;
    end
  end

  assign running = (state == RUN);

  always_comb begin
    state_nxt   = state;
    presc_nxt   = presc;
    ones_nxt    = digit_0;
    tens_nxt    = digit_1;
    tick_nxt    = 1'b0;
    dir_nxt     = count_dir ^ btn_pulse[2];
    step_evt    = (state == RUN) && (presc == PS_LAST);
    step        = (state == RUN) ? step_evt : btn_pulse[3];
    at_limit    = 1'b0;
    lands_limit = 1'b0;

    if (state == RUN) presc_nxt = step_evt ? '0 : presc + PS_W'(1);

    if (btn_pulse[0]) begin
      state_nxt = (state == IDLE) ? RUN : IDLE;
      if (state == IDLE) presc_nxt = '0;
    end

    if (btn_pulse[1]) begin
      // Clear overrides any step landing in the same cycle
      ones_nxt  = 4'd0;
      tens_nxt  = 4'd0;
      presc_nxt = '0;
    end else if (step) begin
      if (count_dir) begin
        if (digit_0 >= 4'd9) begin
          ones_nxt = 4'd0;
          tens_nxt = (digit_1 >= 4'd9) ? 4'd0 : digit_1 + 4'd1;
        end else begin
          ones_nxt = digit_0 + 4'd1;
        end
      end else begin
        if (digit_0 == 4'd0) begin
          ones_nxt = 4'd9;
          tens_nxt = (digit_1 == 4'd0) ? 4'd9 : digit_1 - 4'd1;
        end else begin
          ones_nxt = digit_0 - 4'd1;
        end
      end
      tick_nxt = 1'b1;
`ifdef HOLD_AT_LIMIT_EN
      at_limit    = count_dir ? (digit_1 == 4'd9 && digit_0 == 4'd9)
                              : (digit_1 == 4'd0 && digit_0 == 4'd0);
      lands_limit = count_dir ? (tens_nxt == 4'd9 && ones_nxt == 4'd9)
                              : (tens_nxt == 4'd0 && ones_nxt == 4'd0);
      if (at_limit) begin
        ones_nxt = digit_0;
        tens_nxt = digit_1;
        tick_nxt = 1'b0;
      end else if (lands_limit && state == RUN) begin
        state_nxt = IDLE;
      end
`endif
    end
  end

endmodule
